// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: byte stream in, padded 512-bit blocks out as 16 big-endian 32-bit words.
// Optional macro PADDER_BLOCK_COUNT_EN adds block_count_out, a free-running count of emitted blocks.
module sha256_msg_padder #(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_BYTES_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid_in,
    input  logic                  msg_end_in,
    output logic                  byte_ready_out,
    input  logic                  core_ready_in,
    output logic [DATA_WIDTH-1:0] message_out,
    output logic                  MP_dv_out,
    output logic                  block_last_out
`ifdef PADDER_BLOCK_COUNT_EN
    ,
    output logic [15:0]           block_count_out
`endif
);

    typedef enum logic [2:0] {
        ST_ACCEPT,
        ST_PAD,
        ST_LEN,
        ST_EMIT_WAIT,
        ST_EMIT
    } state_t;

    state_t                  r_state;
    state_t                  r_ret;
    logic [31:0]             r_buf [16];
    logic [5:0]              r_idx;
    logic [MAX_BYTES_W-1:0]  r_cnt;
    logic                    r_first;
    logic                    r_last;
    logic [3:0]              r_word;
    logic                    r_ready;
    logic                    r_dv;
    logic                    r_blast;
    logic [DATA_WIDTH-1:0]   r_msg;
`ifdef PADDER_BLOCK_COUNT_EN
    logic [15:0]             r_blk_cnt;
`endif

    logic                    w_take_byte;
    logic                    w_take_end;
    logic                    w_idx_last;
    logic [4:0]              w_lane_lsb;
    logic [63:0]             w_bitlen;
    logic [7:0]              w_pad_byte;

    assign w_take_byte = (r_state == ST_ACCEPT) && r_ready && byte_valid_in;
    assign w_take_end  = (r_state == ST_ACCEPT) && r_ready && msg_end_in;
    assign w_idx_last  = (r_idx == 6'd63);
    // Big-endian packing: byte 0 of each word lands in bits [31:24].
    assign w_lane_lsb  = {~r_idx[1:0], 3'b000};
    assign w_bitlen    = {{(64-MAX_BYTES_W-3){1'b0}}, r_cnt, 3'b000};
    assign w_pad_byte  = r_first ? 8'h80 : 8'h00;

    assign byte_ready_out = r_ready;
    assign message_out    = r_msg;
    assign MP_dv_out      = r_dv;
    assign block_last_out = r_blast;
`ifdef PADDER_BLOCK_COUNT_EN
    assign block_count_out = r_blk_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCEPT;
            r_ret   <= ST_ACCEPT;
            for (int unsigned i = 0; i < 16; i++) begin
                r_buf[i] <= '0;
            end
            r_idx   <= '0;
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_word  <= '0;
            r_ready <= 1'b0;
            r_dv    <= 1'b0;
            r_blast <= 1'b0;
            r_msg   <= '0;
`ifdef PADDER_BLOCK_COUNT_EN
            r_blk_cnt <= '0;
`endif
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    r_ready <= 1'b1;
                    if (w_take_byte) begin
                        r_buf[r_idx[5:2]][w_lane_lsb +: 8] <= byte_in;
                        r_idx <= r_idx + 6'd1;
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // A byte that fills the block with an end strobe alongside: emit first, pad afterwards.
                    if (w_take_byte && w_idx_last) begin
                        r_state <= ST_EMIT_WAIT;
                        r_last  <= 1'b0;
                        r_ret   <= w_take_end ? ST_PAD : ST_ACCEPT;
                        r_first <= w_take_end;
                        r_ready <= 1'b0;
                    end else if (w_take_end) begin
                        r_state <= ST_PAD;
                        r_first <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end

                ST_PAD: begin
                    r_buf[r_idx[5:2]][w_lane_lsb +: 8] <= w_pad_byte;
                    r_idx   <= r_idx + 6'd1;
                    r_first <= 1'b0;
                    if (w_idx_last) begin
                        r_state <= ST_EMIT_WAIT;
                        r_last  <= 1'b0;
                        r_ret   <= ST_PAD;
                    end else if (r_idx == 6'd55) begin
                        r_state <= ST_LEN;
                    end
                end

                ST_LEN: begin
                    r_buf[14] <= w_bitlen[63:32];
                    r_buf[15] <= w_bitlen[31:0];
                    r_last    <= 1'b1;
                    r_idx     <= '0;
                    r_state   <= ST_EMIT_WAIT;
                end

                ST_EMIT_WAIT: begin
                    if (core_ready_in) begin
                        r_state <= ST_EMIT;
                        r_word  <= '0;
                        r_msg   <= r_buf[0];
                        r_dv    <= 1'b1;
                        r_blast <= r_last;
                    end
                end

                ST_EMIT: begin
                    if (r_word == 4'd15) begin
                        r_dv    <= 1'b0;
                        r_blast <= 1'b0;
                        r_msg   <= '0;
`ifdef PADDER_BLOCK_COUNT_EN
                        r_blk_cnt <= r_blk_cnt + 16'd1;
`endif
                        if (r_last) begin
                            r_state <= ST_ACCEPT;
                            r_cnt   <= '0;
                            r_last  <= 1'b0;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= r_ret;
                            r_ready <= (r_ret == ST_ACCEPT);
                        end
                    end else begin
                        r_word <= r_word + 4'd1;
                        r_msg  <= r_buf[r_word + 4'd1];
                    end
                end

                default: begin
                    r_state <= ST_ACCEPT;
                end
            endcase
        end
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream stage of SHA256_core: turns a raw byte stream into padded 512-bit SHA-256 blocks (FIPS 180-4 padding plus 64-bit big-endian bit length).
- Each block is emitted as 16 consecutive 32-bit words on message_out, qualified by MP_dv_out, matching the core's MP_dv_in / message_in inputs.
- Supports multi-block messages and the empty message.

Parameters:
- DATA_WIDTH, 32, output word width; only 32 is supported.
- MAX_BYTES_W, 32, width of the internal byte counter; the bit length is byte_count << 3, zero-extended to 64 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- byte_in  input  8  message byte.
- byte_valid_in  input  1  byte_in valid; accepted only when byte_ready_out=1.
- msg_end_in  input  1  single-cycle strobe marking end of message; carries no byte; accepted only when byte_ready_out=1.
- byte_ready_out  output  1  padder can accept a byte or end strobe this cycle.
- core_ready_in  input  1  core can take a new block.
- message_out  output  DATA_WIDTH  block word, big-endian (first byte in [31:24]).
- MP_dv_out  output  1  message_out valid.
- block_last_out  output  1  high with every word of the final block of a message.

Behaviour:
- Reset: all outputs 0 except byte_ready_out=1 one cycle after rst deasserts. Reset clears buffer, byte counter and FSM, and aborts any emission in progress; MP_dv_out falls to 0 on the cycle after rst is sampled high.
- Buffer: 16x32 block buffer plus a 6-bit byte index idx (0..63) and a MAX_BYTES_W total-byte counter.
- FSM states:
  - ACCEPT: byte_ready_out=1. An accepted byte is written at idx, and idx and the counter increment. After the byte that makes idx wrap 63->0, go to EMIT_WAIT (block not last). An accepted msg_end_in goes to PAD.
  - PAD: byte_ready_out=0. Writes 0x80 at idx on the first cycle, then one 0x00 byte per cycle until idx=56.
    - If idx>56 after the 0x80, zero-fill to 63, emit that block as non-last, then continue zero-fill in a fresh block to idx=56.
    - At idx=56 go to LEN.
  - LEN: writes the 64-bit bit length (counter*8) into words 14,15 in one cycle, marks the block last, and goes to EMIT_WAIT.
  - EMIT_WAIT: hold until core_ready_in=1, then go to EMIT.
  - EMIT: MP_dv_out=1 for exactly 16 consecutive cycles carrying words 0..15. core_ready_in is ignored once emission has started. block_last_out equals the last flag for all 16 words.
    - After word 15: a last block returns to ACCEPT and clears the counter; a non-last block returns to the state that requested emission (ACCEPT or PAD).
- byte_valid_in and msg_end_in high together: the byte is taken first and the end strobe is honoured in the same cycle, so the byte is counted before padding.
- Inputs arriving while byte_ready_out=0 are ignored; the source must hold them.
- Latency: from msg_end_in acceptance to first MP_dv_out is (57 - idx_at_end) cycles plus core wait, for idx_at_end<=55. It is longer when a second block is needed.
- Counter overflow beyond 2^MAX_BYTES_W bytes wraps silently.

Optional Feature:
- Macro PADDER_BLOCK_COUNT_EN.
- Defined: adds output block_count_out [15:0]. It increments on the cycle after each block's word 15, clears on rst, and never clears on message end (wraps at 65535).
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- "abc" (0x61,0x62,0x63) then msg_end_in -> one block, block_last_out=1: word0=61626380, words1-14=00000000, word15=00000018.
- msg_end_in with no bytes -> one last block: word0=80000000, words1-15=00000000.
- 55 bytes of 0x41 -> one block: word13=41414180, word14=00000000, word15=000001B8.
- 56 bytes of 0x41 -> two blocks:
  - First block: word13=41414141, word14=80000000, block_last_out=0.
  - Second block: words0-14=0, word15=000001C0, block_last_out=1.
- 64 bytes of 0x00 with core_ready_in held low for 20 cycles -> no MP_dv_out until core_ready_in rises, then 16 contiguous words. Second block word0=80000000, word15=00000200.
- rst pulsed during word 5 of an emission -> MP_dv_out=0 the next cycle. A following "abc" message produces the exact block from the first scenario.
